// File: rtl/hash_row_buffer.sv
// Ping-pong row buffer: packs the hash-core word stream into two banks and serves BRAM-style reads.
// Optional sticky underrun detection is enabled with `define HASH_ROW_BUFFER_ERRCHK_EN.
module hash_row_buffer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ROW_WORDS  = 336,
  parameter int unsigned ADDR_LSB   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hash_valid,
  input  logic [DATA_WIDTH-1:0] hash_data,
  output logic                  hash_in_ready,
  input  logic [31:0]           addr_HASH,
  input  logic                  wen_HASH,
  input  logic [DATA_WIDTH-1:0] bram_wdata_HASH,
  output logic [DATA_WIDTH-1:0] bram_data_HASH,
  output logic                  HASH_ready,
  output logic [15:0]           rows_served
`ifdef HASH_ROW_BUFFER_ERRCHK_EN
  ,
  output logic                  underrun_err
`endif
);

  localparam int unsigned DEPTH  = 2 * ROW_WORDS;
  localparam int unsigned PTR_W  = $clog2(ROW_WORDS);
  localparam int unsigned MEM_AW = $clog2(DEPTH);
  localparam int unsigned IDX_W  = 32 - ADDR_LSB;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_bank_q, wr_bank_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            full_q, full_d;
  logic [15:0]           rows_served_q, rows_served_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [IDX_W-1:0]  idx_c;
  logic [IDX_W-1:0]  last_idx_c;
  logic [MEM_AW-1:0] mem_addr_c;
  logic [MEM_AW-1:0] prod_addr_c;
  logic              in_range_c;
  logic              idx_bank_c;
  logic              accept_c;
  logic              fill_done_c;
  logic              release_c;

  // Address decode for the consumer port
  assign idx_c       = addr_HASH[31:ADDR_LSB];
  assign in_range_c  = idx_c < IDX_W'(DEPTH);
  assign mem_addr_c  = MEM_AW'(idx_c);
  assign idx_bank_c  = idx_c >= IDX_W'(ROW_WORDS);
  assign last_idx_c  = rd_bank_q ? IDX_W'(DEPTH - 1) : IDX_W'(ROW_WORDS - 1);
  assign prod_addr_c = wr_bank_q ? (MEM_AW'(ROW_WORDS) + MEM_AW'(wr_ptr_q)) : MEM_AW'(wr_ptr_q);

  assign hash_in_ready = !rst && !full_q[wr_bank_q];
  assign HASH_ready    = !rst && full_q[rd_bank_q];

  assign accept_c    = hash_valid && hash_in_ready;
  assign fill_done_c = accept_c && (wr_ptr_q == PTR_W'(ROW_WORDS - 1));
  assign release_c   = !wen_HASH && HASH_ready && (idx_c == last_idx_c);

  // Fill and release touch different banks, so both updates can land in one cycle
  always_comb begin
    wr_bank_d     = wr_bank_q;
    wr_ptr_d      = wr_ptr_q;
    rd_bank_d     = rd_bank_q;
    full_d        = full_q;
    rows_served_d = rows_served_q;
    rd_data_d     = rd_data_q;

    if (accept_c) begin
      if (fill_done_c) begin
        wr_ptr_d          = '0;
        wr_bank_d         = !wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end

    if (release_c) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
      rows_served_d     = rows_served_q + 16'd1;
    end

    if (!wen_HASH) begin
      rd_data_d = in_range_c ? mem_q[mem_addr_c] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_bank_q     <= 1'b0;
      full_q        <= 2'b00;
      rows_served_q <= 16'd0;
      rd_data_q     <= '0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      rows_served_q <= rows_served_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Consumer write is issued last so it wins a same-index collision
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem_q[prod_addr_c] <= hash_data;
    end
    if (wen_HASH && in_range_c) begin
      mem_q[mem_addr_c] <= bram_wdata_HASH;
    end
  end

  assign bram_data_HASH = rd_data_q;
  assign rows_served    = rows_served_q;

`ifdef HASH_ROW_BUFFER_ERRCHK_EN
  logic err_q, err_d;

  // Handshake-qualified overwrite term is a guard against future changes to ready
  always_comb begin
    err_d = err_q;
    if (!wen_HASH && in_range_c && !full_q[idx_bank_c]) begin
      err_d = 1'b1;
    end
    if (accept_c && full_q[wr_bank_q]) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign underrun_err = err_q;
`endif

endmodule

// File: tb/tb_hash_row_buffer.sv
// Randomized self-checking bench for hash_row_buffer with a bank-count reference model.
module tb_hash_row_buffer;

  localparam int RW    = 336;
  localparam int DEPTH = 2 * RW;
  localparam logic [31:0] IDLE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        hash_valid;
  logic [63:0] hash_data;
  logic        hash_in_ready;
  logic [31:0] addr_HASH;
  logic        wen_HASH;
  logic [63:0] bram_wdata_HASH;
  logic [63:0] bram_data_HASH;
  logic        HASH_ready;
  logic [15:0] rows_served;
`ifdef HASH_ROW_BUFFER_ERRCHK_EN
  logic        underrun_err;
`endif

  always #5 clk = ~clk;

  hash_row_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .hash_valid      (hash_valid),
    .hash_data       (hash_data),
    .hash_in_ready   (hash_in_ready),
    .addr_HASH       (addr_HASH),
    .wen_HASH        (wen_HASH),
    .bram_wdata_HASH (bram_wdata_HASH),
    .bram_data_HASH  (bram_data_HASH),
    .HASH_ready      (HASH_ready),
    .rows_served     (rows_served)
`ifdef HASH_ROW_BUFFER_ERRCHK_EN
    ,
    .underrun_err    (underrun_err)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: words accepted and rows released since reset; banks follow from the counts
  logic [63:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  int          m_acc = 0;
  int          m_rel = 0;
  logic [63:0] m_bram = '0;
  bit          m_bram_known = 1'b0;
  bit          m_err = 1'b0;
  bit          started = 1'b0;

  function automatic int outstanding();
    return m_acc / RW - m_rel;
  endfunction

  function automatic bit m_full(input int b);
    int o;
    o = outstanding();
    return (o == 2) || (o == 1 && b == m_rel % 2);
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int idx;
    int o;
    int p;
    bit inr;
    bit rel;
    bit acc;
    idx = int'(addr_HASH >> 3);
    inr = idx < DEPTH;
    o   = outstanding();
    if (wen_HASH && inr && rst) begin
      m_mem[idx]   = bram_wdata_HASH;
      m_known[idx] = 1'b1;
    end
    if (rst) begin
      m_acc        = 0;
      m_rel        = 0;
      m_bram       = '0;
      m_bram_known = 1'b1;
      m_err        = 1'b0;
      started      = 1'b1;
    end else begin
      rel = !wen_HASH && o >= 1 && idx == (m_rel % 2) * RW + RW - 1;
      acc = hash_valid && o < 2;
      if (!wen_HASH && inr && !m_full(idx / RW)) m_err = 1'b1;
      if (!wen_HASH) begin
        if (inr) begin
          m_bram       = m_mem[idx];
          m_bram_known = m_known[idx];
        end else begin
          m_bram       = '0;
          m_bram_known = 1'b1;
        end
      end
      if (acc) begin
        p          = ((m_acc / RW) % 2) * RW + m_acc % RW;
        m_mem[p]   = hash_data;
        m_known[p] = 1'b1;
        m_acc++;
      end
      if (wen_HASH && inr) begin
        m_mem[idx]   = bram_wdata_HASH;
        m_known[idx] = 1'b1;
      end
      if (rel) m_rel++;
    end
  end

  // Per-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    if (started) begin
      chk("cmp_hash_in_ready", 64'(hash_in_ready), 64'(!rst && outstanding() < 2));
      chk("cmp_HASH_ready", 64'(HASH_ready), 64'(!rst && outstanding() >= 1));
      chk("cmp_rows_served", 64'(rows_served), 64'(16'(m_rel)));
      if (m_bram_known) chk("cmp_bram_data", bram_data_HASH, m_bram);
`ifdef HASH_ROW_BUFFER_ERRCHK_EN
      chk("cmp_underrun_err", 64'(underrun_err), 64'(m_err));
`endif
    end
  end

  task automatic step(input bit r, input bit hv, input logic [63:0] hd,
                      input logic [31:0] a, input bit w, input logic [63:0] wd);
    #1;
    rst             = r;
    hash_valid      = hv;
    hash_data       = hd;
    addr_HASH       = a;
    wen_HASH        = w;
    bram_wdata_HASH = wd;
    @(negedge clk);
  endtask

  task automatic rd(input int k);
    step(1'b0, 1'b0, 64'd0, 32'(k) << 3, 1'b0, 64'd0);
  endtask

  initial begin
    int sel;
    int idx;
    bit r;
    rst = 1'b1; hash_valid = 1'b0; hash_data = '0;
    addr_HASH = IDLE; wen_HASH = 1'b0; bram_wdata_HASH = '0;
    @(negedge clk);
    step(1'b1, 1'b0, 64'd0, IDLE, 1'b0, 64'd0);
    chk("rst_hash_in_ready", 64'(hash_in_ready), 64'd0);
    chk("rst_HASH_ready", 64'(HASH_ready), 64'd0);
    chk("rst_rows_served", 64'(rows_served), 64'd0);
    chk("rst_bram_data", bram_data_HASH, 64'd0);

    // Fill bank 0 with 0..335
    for (int k = 0; k < RW; k++) begin
      step(1'b0, 1'b1, 64'(k), IDLE, 1'b0, 64'd0);
      if (k == RW - 2) chk("fill_ready_early", 64'(HASH_ready), 64'd0);
    end
    chk("fill_ready", 64'(HASH_ready), 64'd1);
    rd(0);   chk("fill_rd0", bram_data_HASH, 64'd0);
    rd(1);   chk("fill_rd1", bram_data_HASH, 64'd1);
    rd(335); chk("fill_rd335", bram_data_HASH, 64'd335);
    chk("fill_rows", 64'(rows_served), 64'd1);
    chk("fill_ready_after_rel", 64'(HASH_ready), 64'd0);

    // Backpressure with both banks full
    step(1'b1, 1'b0, 64'd0, IDLE, 1'b0, 64'd0);
    for (int i = 0; i < 700; i++) step(1'b0, 1'b1, 64'(1000 + i), IDLE, 1'b0, 64'd0);
    chk("bp_in_ready", 64'(hash_in_ready), 64'd0);
    chk("bp_HASH_ready", 64'(HASH_ready), 64'd1);
    chk("bp_rows", 64'(rows_served), 64'd0);
    step(1'b0, 1'b1, 64'd1672, 32'(335) << 3, 1'b0, 64'd0);
    chk("bp_rel_rows", 64'(rows_served), 64'd1);
    chk("bp_rel_in_ready", 64'(hash_in_ready), 64'd1);
    chk("bp_rel_data", bram_data_HASH, 64'd1335);
    step(1'b0, 1'b1, 64'd1672, IDLE, 1'b0, 64'd0);
    rd(0);   chk("bp_held_word", bram_data_HASH, 64'd1672);
    rd(336); chk("bp_bank1_rd", bram_data_HASH, 64'd1336);
    chk("bp_bank1_ready", 64'(HASH_ready), 64'd1);

    // Release only on the last word of the current bank
    step(1'b1, 1'b0, 64'd0, IDLE, 1'b0, 64'd0);
    for (int k = 0; k < RW; k++) step(1'b0, 1'b1, 64'(2000 + k), IDLE, 1'b0, 64'd0);
    for (int rep = 0; rep < 2; rep++)
      for (int k = 0; k < RW - 1; k++) rd(k);
    chk("norel_ready", 64'(HASH_ready), 64'd1);
    chk("norel_rows", 64'(rows_served), 64'd0);
    chk("norel_data", bram_data_HASH, 64'd2334);
    rd(335);
    chk("rel_ready", 64'(HASH_ready), 64'd0);
    chk("rel_rows", 64'(rows_served), 64'd1);

    // Consumer write holds read data, then reads back
    step(1'b0, 1'b0, 64'd0, 32'(5) << 3, 1'b1, 64'hDEAD_BEEF_0000_0005);
    chk("cw_hold", bram_data_HASH, 64'd2335);
    chk("cw_ready", 64'(HASH_ready), 64'd0);
    rd(5);   chk("cw_readback", bram_data_HASH, 64'hDEAD_BEEF_0000_0005);
    rd(672); chk("oor_read", bram_data_HASH, 64'd0);

    // Reset mid-row discards the partial fill
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 64'(3000 + i), IDLE, 1'b0, 64'd0);
    rd(50);
    step(1'b1, 1'b0, 64'd0, IDLE, 1'b0, 64'd0);
    chk("mid_rst_ready", 64'(HASH_ready), 64'd0);
    chk("mid_rst_rows", 64'(rows_served), 64'd0);
    chk("mid_rst_bram", bram_data_HASH, 64'd0);
    for (int k = 0; k < RW; k++) step(1'b0, 1'b1, 64'(4000 + k), IDLE, 1'b0, 64'd0);
    chk("mid_refill_ready", 64'(HASH_ready), 64'd1);
    rd(0);  chk("mid_refill_rd0", bram_data_HASH, 64'd4000);
    rd(99); chk("mid_refill_rd99", bram_data_HASH, 64'd4099);

`ifdef HASH_ROW_BUFFER_ERRCHK_EN
    step(1'b1, 1'b0, 64'd0, IDLE, 1'b0, 64'd0);
    chk("err_rst", 64'(underrun_err), 64'd0);
    rd(0);
    chk("err_set", 64'(underrun_err), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'd0, IDLE, 1'b0, 64'd0);
    chk("err_sticky", 64'(underrun_err), 64'd1);
    step(1'b1, 1'b0, 64'd0, IDLE, 1'b0, 64'd0);
    chk("err_clear", 64'(underrun_err), 64'd0);
`endif

    // Randomized traffic, checked each cycle by the compare process
    for (int n = 0; n < 4000; n++) begin
      r   = ($urandom_range(0, 499) == 0);
      sel = int'($urandom_range(0, 99));
      if (sel < 25)      idx = (m_rel % 2) * RW + RW - 1;
      else if (sel < 30) idx = ((m_rel + 1) % 2) * RW + RW - 1;
      else if (sel < 35) idx = DEPTH + int'($urandom_range(0, 99));
      else               idx = int'($urandom_range(0, DEPTH - 1));
      step(r, $urandom_range(0, 9) < 7, {$urandom, $urandom},
           (32'(idx) << 3) | 32'($urandom_range(0, 7)),
           !r && ($urandom_range(0, 9) == 0), {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
